// File: rtl/wave_capture_ctrl.sv
// Waveform capture controller: arms on a positive zero crossing, writes one buffer half of
// offset-binary samples, then waits for the display to go idle before swapping halves.
module wave_capture_ctrl #(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned ADDR_LSB_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample_ready,
    input  logic [SAMPLE_W-1:0]   new_sample_in,
    input  logic                  wave_display_idle,
    output logic [ADDR_LSB_W:0]   write_address,
    output logic                  write_enable,
    output logic [7:0]            write_sample,
    output logic                  read_index
);

    typedef enum logic [1:0] {
        StArmed,
        StActive,
        StWait
    } state_e;

    localparam logic [ADDR_LSB_W-1:0] CountMax = '1;

    state_e                  state_q, state_d;
    logic [ADDR_LSB_W-1:0]   count_q, count_d;
    logic                    prev_neg_q, prev_neg_d;
    logic                    read_index_q, read_index_d;
    logic                    write_enable_q, write_enable_d;
    logic [7:0]              write_sample_q, write_sample_d;
    logic [ADDR_LSB_W:0]     write_address_q, write_address_d;

    logic sample_neg;
    logic crossing;
    logic unused_sample_lsbs;

    assign sample_neg = new_sample_in[SAMPLE_W-1];
    assign crossing   = new_sample_ready && prev_neg_q && !sample_neg;

    // Only the top 8 bits reach the display RAM.
    assign unused_sample_lsbs = ^new_sample_in[SAMPLE_W-9:0];

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        prev_neg_d      = prev_neg_q;
        read_index_d    = read_index_q;
        write_enable_d  = 1'b0;
        write_sample_d  = write_sample_q;
        write_address_d = write_address_q;

        if (new_sample_ready) begin
            prev_neg_d = sample_neg;
        end

        unique case (state_q)
            StArmed: begin
                if (crossing) begin
                    state_d = StActive;
                    count_d = '0;
                end
            end
            StActive: begin
                if (new_sample_ready) begin
                    write_enable_d  = 1'b1;
                    write_address_d = {~read_index_q, count_q};
                    // Offset binary: flipping the sign bit adds 128 mod 256.
                    write_sample_d  = {~sample_neg, new_sample_in[SAMPLE_W-2 -: 7]};
                    count_d         = count_q + 1'b1;
                    if (count_q == CountMax) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (wave_display_idle) begin
                    state_d      = StArmed;
                    read_index_d = ~read_index_q;
                end
            end
            default: begin
                state_d = StArmed;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StArmed;
            count_q         <= '0;
            prev_neg_q      <= 1'b0;
            read_index_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_sample_q  <= '0;
            write_address_q <= {1'b1, {ADDR_LSB_W{1'b0}}};
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            prev_neg_q      <= prev_neg_d;
            read_index_q    <= read_index_d;
            write_enable_q  <= write_enable_d;
            write_sample_q  <= write_sample_d;
            write_address_q <= write_address_d;
        end
    end

    assign write_address = write_address_q;
    assign write_enable  = write_enable_q;
    assign write_sample  = write_sample_q;
    assign read_index    = read_index_q;

endmodule

// File: doc/wave_capture_ctrl.md
WAVE_CAPTURE_CTRL -- requirements
Module: wave_capture_ctrl

Interface
REQ-001 Parameter: SAMPLE_W, 16, width of the signed two's-complement audio sample input.
REQ-002 Parameter: ADDR_LSB_W, 8, width of the per-half address counter (256 samples per buffer half).
REQ-003 Port: clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: new_sample_ready  input  1  single-cycle strobe; each high cycle is exactly one new sample.
REQ-006 Port: new_sample_in  input  SAMPLE_W  signed sample, valid when new_sample_ready=1.
REQ-007 Port: wave_display_idle  input  1  high while the display is outside the waveform region (safe to swap buffers).
REQ-008 Port: write_address  output  ADDR_LSB_W+1  RAM write address, {~read_index, count}.
REQ-009 Port: write_enable  output  1  RAM write strobe, one cycle per written sample.
REQ-010 Port: write_sample  output  8  unsigned offset-binary sample for the display RAM.
REQ-011 Port: read_index  output  1  buffer half the display reads; the controller SHALL write only the other half.

Function
REQ-012 The FSM SHALL have three states: ARMED, ACTIVE, WAIT.
REQ-013 Register prev_neg SHALL load new_sample_in[SAMPLE_W-1] on every new_sample_ready cycle, in all states.
REQ-014 Positive zero crossing SHALL be defined as prev_neg=1 and new_sample_in[SAMPLE_W-1]=0 on a new_sample_ready cycle.
REQ-015 ARMED -> ACTIVE on a crossing; count SHALL be 0 on entry; the crossing sample itself SHALL NOT be written.
REQ-016 In ACTIVE, each new_sample_ready SHALL produce, on the next cycle, write_enable=1 for exactly one cycle with write_address={~read_index, count} (count value at strobe time).
REQ-017 write_sample SHALL be {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]} (top 8 bits + 128, mod 256), registered alongside write_enable.
REQ-018 count SHALL increment by 1 after each ACTIVE write strobe; when the strobed count is 255, state SHALL go ACTIVE -> WAIT and count SHALL wrap to 0.
REQ-019 In WAIT, new_sample_ready SHALL cause no write; prev_neg still updates.
REQ-020 WAIT -> ARMED when wave_display_idle=1; read_index SHALL toggle on that same edge.
REQ-021 read_index SHALL change only on the WAIT -> ARMED transition.
REQ-022 Simultaneous wave_display_idle and new_sample_ready in WAIT: swap occurs; that sample updates prev_neg but SHALL NOT trigger (trigger is evaluated in ARMED only).
REQ-023 wave_display_idle SHALL be ignored in ARMED and ACTIVE.
REQ-024 A crossing in ACTIVE or WAIT SHALL have no effect.
REQ-025 write_enable SHALL be 0 in every cycle not described in REQ-016.

Reset
REQ-026 While reset=1 and immediately on its assertion (asynchronously): state=ARMED, count=0, prev_neg=0, read_index=0, write_enable=0, write_sample=0, write_address=9'h100.
REQ-027 Reset asserted mid-ACTIVE SHALL abort the capture with no further writes; the partially written half is not cleared.
REQ-028 After reset release, the first trigger SHALL require one negative sample followed by one non-negative sample.

Verification
REQ-029 Reset, then samples 16'h0100, 16'h8000, 16'h0010 (strobed) -> no write until after 16'h0010; state ACTIVE, no write for 16'h0010 itself.
REQ-030 In ACTIVE, strobe sample 16'h7F00 -> next cycle write_enable=1, write_address=9'h100, write_sample=8'hFF; strobe 16'h8000 -> write_address=9'h101, write_sample=8'h00.
REQ-031 Complete 256 strobes -> last write at 9'h1FF, state WAIT; 10 further strobes -> write_enable stays 0, read_index stays 0.
REQ-032 In WAIT, pulse wave_display_idle -> read_index=1 next edge; next trigger + sample -> write_address=9'h000.
REQ-033 Assert reset after 100 ACTIVE writes -> outputs at REQ-026 values immediately (before the next clk edge); a crossing then restarts at address 9'h100.
REQ-034 In WAIT, assert wave_display_idle and a negative-to-positive strobe in the same cycle -> read_index toggles, state ARMED, no write and no trigger.
